// File: rtl/usrdemux_stream.sv
// usrdemux_stream: 1:2 packet-routed stream demux with registered outputs.
// Output select is locked for the duration of a packet.
module usrdemux_stream #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             usrdemux_sel,
  input  logic [WIDTH-1:0] usrdemux_i_data,
  input  logic             usrdemux_i_last,
  input  logic             usrdemux_i_valid,
  output logic             usrdemux_i_ready,
  output logic [WIDTH-1:0] usrdemux_o0_data,
  output logic             usrdemux_o0_last,
  output logic             usrdemux_o0_valid,
  input  logic             usrdemux_o0_ready,
  output logic [WIDTH-1:0] usrdemux_o1_data,
  output logic             usrdemux_o1_last,
  output logic             usrdemux_o1_valid,
  input  logic             usrdemux_o1_ready,
  output logic             usrdemux_busy,
  output logic [CNT_W-1:0] usrdemux_cnt0,
  output logic [CNT_W-1:0] usrdemux_cnt1
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             lock_q, lock_d;
  logic [WIDTH-1:0] data0_q, data0_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic             last0_q, last0_d;
  logic             last1_q, last1_d;
  logic             valid0_q, valid0_d;
  logic             valid1_q, valid1_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic target;
  logic free0, free1;
  logic acc, ld0, ld1;
  logic drain0, drain1;

  always_comb begin
    target = (state_q == LOCKED) ? lock_q : usrdemux_sel;
    drain0 = valid0_q && usrdemux_o0_ready;
    drain1 = valid1_q && usrdemux_o1_ready;
    // A full register still counts as free if it drains this cycle
    free0  = !valid0_q || usrdemux_o0_ready;
    free1  = !valid1_q || usrdemux_o1_ready;
    usrdemux_i_ready = target ? free1 : free0;
    acc = usrdemux_i_valid && usrdemux_i_ready;
    ld0 = acc && !target;
    ld1 = acc && target;
  end

  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    last0_d  = last0_q;
    last1_d  = last1_q;
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;

    if (acc) begin
      if (usrdemux_i_last) begin
        state_d = IDLE;
      end else begin
        state_d = LOCKED;
        lock_d  = target;
      end
    end

    if (ld0) begin
      data0_d  = usrdemux_i_data;
      last0_d  = usrdemux_i_last;
      valid0_d = 1'b1;
    end else if (drain0) begin
      valid0_d = 1'b0;
    end

    if (ld1) begin
      data1_d  = usrdemux_i_data;
      last1_d  = usrdemux_i_last;
      valid1_d = 1'b1;
    end else if (drain1) begin
      valid1_d = 1'b0;
    end

    if (drain0 && cnt0_q != CNT_MAX) cnt0_d = cnt0_q + 1'b1;
    if (drain1 && cnt1_q != CNT_MAX) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lock_q   <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
      last0_q  <= 1'b0;
      last1_q  <= 1'b0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      last0_q  <= last0_d;
      last1_q  <= last1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  assign usrdemux_o0_data  = data0_q;
  assign usrdemux_o0_last  = last0_q;
  assign usrdemux_o0_valid = valid0_q;
  assign usrdemux_o1_data  = data1_q;
  assign usrdemux_o1_last  = last1_q;
  assign usrdemux_o1_valid = valid1_q;
  assign usrdemux_busy     = (state_q == LOCKED);
  assign usrdemux_cnt0     = cnt0_q;
  assign usrdemux_cnt1     = cnt1_q;

endmodule

// File: tb/tb_usrdemux_stream.sv
// tb_usrdemux_stream: directed scenarios plus a randomized run scored
// against a packet-level queue model of the demux.
module tb_usrdemux_stream;

  localparam int W  = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          sel;
  logic [W-1:0]  i_data;
  logic          i_last;
  logic          i_valid;
  logic          i_ready;
  logic [W-1:0]  o0_data;
  logic          o0_last;
  logic          o0_valid;
  logic          o0_ready;
  logic [W-1:0]  o1_data;
  logic          o1_last;
  logic          o1_valid;
  logic          o1_ready;
  logic          busy;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  usrdemux_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .usrdemux_sel     (sel),
    .usrdemux_i_data  (i_data),
    .usrdemux_i_last  (i_last),
    .usrdemux_i_valid (i_valid),
    .usrdemux_i_ready (i_ready),
    .usrdemux_o0_data (o0_data),
    .usrdemux_o0_last (o0_last),
    .usrdemux_o0_valid(o0_valid),
    .usrdemux_o0_ready(o0_ready),
    .usrdemux_o1_data (o1_data),
    .usrdemux_o1_last (o1_last),
    .usrdemux_o1_valid(o1_valid),
    .usrdemux_o1_ready(o1_ready),
    .usrdemux_busy    (busy),
    .usrdemux_cnt0    (cnt0),
    .usrdemux_cnt1    (cnt1)
  );

  task automatic drive(input logic s, input logic [W-1:0] d,
                       input logic l, input logic v);
    sel = s; i_data = d; i_last = l; i_valid = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    o0_ready = 1'b1; o1_ready = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if ({o0_valid, o1_valid, busy, cnt0, cnt1} !== '0)
      $display("FAIL reset_flags got v0=%b v1=%b busy=%b c0=%0d c1=%0d exp all 0",
               o0_valid, o1_valid, busy, cnt0, cnt1);
    else n_pass++;
    n_total++;
    if ({o0_data, o1_data, o0_last, o1_last} !== '0)
      $display("FAIL reset_data got d0=%h d1=%h exp 0", o0_data, o1_data);
    else n_pass++;
    n_total++;
    if (i_ready !== 1'b1)
      $display("FAIL reset_i_ready got %b exp 1", i_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    o0_ready = 1'b0; o1_ready = 1'b0;
    drive(1'b1, 64'h1, 1'b0, 1'b1);
    @(negedge clk);
    n_total++;
    if (o1_valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL rmid_first got v1=%b busy=%b exp 1 1", o1_valid, busy);
    else n_pass++;
    drive(1'b1, 64'h2, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 64'h77, 1'b1, 1'b1);
    n_total++;
    if (o1_valid !== 1'b0 || busy !== 1'b0 || cnt1 !== '0)
      $display("FAIL rmid_after got v1=%b busy=%b c1=%0d exp 0 0 0",
               o1_valid, busy, cnt1);
    else n_pass++;
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0);
    n_total++;
    if (o0_valid !== 1'b1 || o0_data !== 64'h77 || o1_valid !== 1'b0)
      $display("FAIL rmid_fresh got v0=%b d0=%h v1=%b exp 1 77 0",
               o0_valid, o0_data, o1_valid);
    else n_pass++;
  endtask

  task automatic test_packet_lock();
    do_reset();
    o0_ready = 1'b1; o1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive((k % 2 == 0), 64'(8'hA0 + k), (k == 3), 1'b1);
      #1;
      n_total++;
      if (i_ready !== 1'b1)
        $display("FAIL lock_i_ready k=%0d got %b exp 1", k, i_ready);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (o1_valid !== 1'b1 || o1_data !== 64'(8'hA0 + k) ||
          o1_last !== (k == 3) || o0_valid !== 1'b0)
        $display("FAIL lock_beat k=%0d got v1=%b d1=%h l1=%b v0=%b exp 1 %h %b 0",
                 k, o1_valid, o1_data, o1_last, o0_valid, 8'hA0 + k, k == 3);
      else n_pass++;
      n_total++;
      if (busy !== (k < 3))
        $display("FAIL lock_busy k=%0d got %b exp %b", k, busy, k < 3);
      else n_pass++;
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    n_total++;
    if (cnt1 !== 4'd4 || cnt0 !== 4'd0 || o1_valid !== 1'b0)
      $display("FAIL lock_cnt got c1=%0d c0=%0d v1=%b exp 4 0 0",
               cnt1, cnt0, o1_valid);
    else n_pass++;
  endtask

  task automatic test_single_alternating();
    do_reset();
    o0_ready = 1'b1; o1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(k[0], 64'(16'hB000 + k), 1'b1, 1'b1);
      #1;
      n_total++;
      if (i_ready !== 1'b1)
        $display("FAIL alt_i_ready k=%0d got %b exp 1", k, i_ready);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (k[0] ? (o1_valid !== 1'b1 || o1_data !== 64'(16'hB000 + k) ||
                  o0_valid !== 1'b0)
               : (o0_valid !== 1'b1 || o0_data !== 64'(16'hB000 + k) ||
                  o1_valid !== 1'b0))
        $display("FAIL alt_route k=%0d got v0=%b d0=%h v1=%b d1=%h exp on o%0d",
                 k, o0_valid, o0_data, o1_valid, o1_data, k[0]);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0)
        $display("FAIL alt_busy k=%0d got %b exp 0", k, busy);
      else n_pass++;
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    n_total++;
    if (cnt0 !== 4'd2 || cnt1 !== 4'd2)
      $display("FAIL alt_cnt got c0=%0d c1=%0d exp 2 2", cnt0, cnt1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    o0_ready = 1'b0; o1_ready = 1'b1;
    drive(1'b0, 64'h11, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 64'h21, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++;
      if (i_ready !== 1'b0 || o0_data !== 64'h11 || o0_valid !== 1'b1)
        $display("FAIL bp_stall k=%0d got rdy=%b d0=%h v0=%b exp 0 11 1",
                 k, i_ready, o0_data, o0_valid);
      else n_pass++;
      @(negedge clk);
    end
    o0_ready = 1'b1;
    #1;
    n_total++;
    if (i_ready !== 1'b1)
      $display("FAIL bp_release got rdy=%b exp 1", i_ready);
    else n_pass++;
    @(negedge clk);
    drive(1'b0, 64'h22, 1'b1, 1'b1);
    n_total++;
    if (o0_data !== 64'h21 || cnt0 !== 4'd1 || busy !== 1'b1)
      $display("FAIL bp_o0_b1 got d0=%h c0=%0d busy=%b exp 21 1 1",
               o0_data, cnt0, busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (o0_data !== 64'h22 || o0_last !== 1'b1 || cnt0 !== 4'd2)
      $display("FAIL bp_o0_b2 got d0=%h l0=%b c0=%0d exp 22 1 2",
               o0_data, o0_last, cnt0);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 64'(8'h31 + k), (k == 2), 1'b1);
      #1;
      n_total++;
      if (i_ready !== 1'b1)
        $display("FAIL bp_o1_rdy k=%0d got %b exp 1", k, i_ready);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (o1_valid !== 1'b1 || o1_data !== 64'(8'h31 + k))
        $display("FAIL bp_o1_beat k=%0d got v1=%b d1=%h exp 1 %h",
                 k, o1_valid, o1_data, 8'h31 + k);
      else n_pass++;
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    n_total++;
    if (cnt1 !== 4'd3 || cnt0 !== 4'd3 || o0_valid || o1_valid)
      $display("FAIL bp_end got c0=%0d c1=%0d v0=%b v1=%b exp 3 3 0 0",
               cnt0, cnt1, o0_valid, o1_valid);
    else n_pass++;
  endtask

  task automatic test_drain_and_load();
    do_reset();
    o0_ready = 1'b0; o1_ready = 1'b1;
    drive(1'b0, 64'h5, 1'b1, 1'b1);
    @(negedge clk);
    o0_ready = 1'b1;
    drive(1'b0, 64'h6, 1'b1, 1'b1);
    #1;
    n_total++;
    if (i_ready !== 1'b1 || o0_data !== 64'h5)
      $display("FAIL dl_pre got rdy=%b d0=%h exp 1 5", i_ready, o0_data);
    else n_pass++;
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0);
    o0_ready = 1'b0;
    n_total++;
    if (o0_valid !== 1'b1 || o0_data !== 64'h6 || cnt0 !== 4'd1)
      $display("FAIL dl_post got v0=%b d0=%h c0=%0d exp 1 6 1",
               o0_valid, o0_data, cnt0);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    o0_ready = 1'b1; o1_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 64'(k), 1'b1, 1'b1);
      @(negedge clk);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    n_total++;
    if (cnt1 !== 4'd15)
      $display("FAIL sat_cnt got %0d exp 15", cnt1);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (cnt1 !== 4'd15 || cnt0 !== 4'd0)
      $display("FAIL sat_hold got c1=%0d c0=%0d exp 15 0", cnt1, cnt0);
    else n_pass++;
  endtask

  // Model: a queue of accepted-but-undelivered beats per output, with
  // packet-level routing (first beat picks the output).
  task automatic test_random();
    logic [W:0] q0[$];
    logic [W:0] q1[$];
    logic [W:0] front;
    logic in_pkt, lock_sel, tgt, exp_rdy, acc;
    int   n0, n1;
    in_pkt = 1'b0; lock_sel = 1'b0; n0 = 0; n1 = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      drive(1'($urandom), {$urandom, $urandom},
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7));
      o0_ready = ($urandom_range(0, 9) < 6);
      o1_ready = ($urandom_range(0, 9) < 6);
      if (c >= 780) i_valid = 1'b0;
      #1;
      tgt = in_pkt ? lock_sel : sel;
      exp_rdy = tgt ? (q1.size() == 0 || o1_ready)
                    : (q0.size() == 0 || o0_ready);
      n_total++;
      if (i_ready !== exp_rdy || busy !== in_pkt ||
          o0_valid !== (q0.size() != 0) || o1_valid !== (q1.size() != 0))
        $display("FAIL rnd_ctl c=%0d got rdy=%b busy=%b v0=%b v1=%b exp %b %b %b %b",
                 c, i_ready, busy, o0_valid, o1_valid, exp_rdy, in_pkt,
                 q0.size() != 0, q1.size() != 0);
      else n_pass++;
      n_total++;
      if (cnt0 !== CW'(n0 > 15 ? 15 : n0) || cnt1 !== CW'(n1 > 15 ? 15 : n1))
        $display("FAIL rnd_cnt c=%0d got %0d %0d exp %0d %0d",
                 c, cnt0, cnt1, n0 > 15 ? 15 : n0, n1 > 15 ? 15 : n1);
      else n_pass++;
      if (o0_valid && o0_ready && q0.size() != 0) begin
        front = q0.pop_front();
        n0++;
        n_total++;
        if ({o0_last, o0_data} !== front)
          $display("FAIL rnd_o0 c=%0d got %b/%h exp %b/%h",
                   c, o0_last, o0_data, front[W], front[W-1:0]);
        else n_pass++;
      end
      if (o1_valid && o1_ready && q1.size() != 0) begin
        front = q1.pop_front();
        n1++;
        n_total++;
        if ({o1_last, o1_data} !== front)
          $display("FAIL rnd_o1 c=%0d got %b/%h exp %b/%h",
                   c, o1_last, o1_data, front[W], front[W-1:0]);
        else n_pass++;
      end
      acc = i_valid && exp_rdy;
      if (acc) begin
        if (tgt) q1.push_back({i_last, i_data});
        else     q0.push_back({i_last, i_data});
        in_pkt   = !i_last;
        lock_sel = tgt;
      end
      @(negedge clk);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    o0_ready = 1'b1; o1_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n0 += q0.size();
    n1 += q1.size();
    n_total++;
    if (o0_valid || o1_valid ||
        cnt0 !== CW'(n0 > 15 ? 15 : n0) || cnt1 !== CW'(n1 > 15 ? 15 : n1))
      $display("FAIL rnd_final got v0=%b v1=%b c0=%0d c1=%0d exp 0 0 %0d %0d",
               o0_valid, o1_valid, cnt0, cnt1,
               n0 > 15 ? 15 : n0, n1 > 15 ? 15 : n1);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    o0_ready = 1'b0; o1_ready = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    test_reset();
    test_reset_mid_packet();
    test_packet_lock();
    test_single_alternating();
    test_backpressure();
    test_drain_and_load();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
